oh_pads_cfgload: RTL
====================

Name: oh_pads_cfgload

Overview:
- Core-side serial transmitter for the pad-ring configuration chain.
- Each GPIO pad slice holds a CFGW-bit shift register driving its sky130 pad mode pins (dm, ie_n, oe_n, slow, hold, etc.).
- This block takes a parallel configuration image and shifts it serially into the daisy chain. It then pulses a load strobe so every pad latches its new word simultaneously.
- Sits in the pad-ring top next to the pad, corner and supply instances, and feeds the first pad slice.

Parameters:
- NPADS, 16: number of configurable pads in the chain (>=1).
- CFGW, 13: configuration bits per pad (>=1).
- DIV, 2: serial clock half-period in clk cycles (>=1).
- AUTOLOAD, 1: 1 = start one transfer automatically after reset release; 0 = wait for start.

Ports:
- clk  input  1  core clock.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to transmit cfg_bus.
- cfg_bus  input  NPADS*CFGW  config image; pad k word at [k*CFGW +: CFGW].
- serial_clk  output  1  chain shift clock; pads sample serial_data on its rising edge.
- serial_data  output  1  chain serial data, into pad 0.
- serial_load  output  1  chain latch strobe; pads copy shift reg to active config while high.
- busy  output  1  transfer in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (nreset low, asynchronous): all outputs 0, state IDLE, counters 0, shift register 0, autoload pending flag set.
- Chain order: serial_data enters pad 0 and propagates toward pad NPADS-1. The bit index sequence is NPADS*CFGW-1 down to 0, so the first bit sent ends at pad NPADS-1 MSB.
- IDLE:
  - Transfer trigger: start==1, or autoload pending with AUTOLOAD==1. Autoload fires in the first clk after nreset deasserts.
  - On trigger: latch cfg_bus into the shift register, clear autoload pending, go to SLO. busy=1 from the next cycle.
- SLO (DIV cycles):
  - serial_clk=0.
  - serial_data = current MSB of the shift register, stable for the whole state.
  - Then go to SHI.
- SHI (DIV cycles):
  - serial_clk=1; serial_data unchanged.
  - On exit, shift the register left by 1 and increment the bit counter.
  - If NPADS*CFGW bits have been sent, go to LOAD; otherwise go to SLO.
- LOAD (DIV cycles):
  - serial_clk=0, serial_data=0, serial_load=1.
  - Then go to FIN.
- FIN (1 cycle): done=1, busy=0, serial_load=0, then IDLE.
- Latency: busy is high for exactly 2*DIV*NPADS*CFGW + DIV cycles. done follows the last busy cycle.
- start while busy or during FIN: ignored; no queuing.
- cfg_bus changes during a transfer: no effect, because the image is captured at trigger.
- start and autoload in the same cycle: a single transfer.
- Reset mid-transfer:
  - Outputs return to 0 immediately and serial_load is never raised.
  - Pads keep their previous active config; their shift registers hold partial data, which the next full transfer overwrites.
  - With AUTOLOAD=1, a fresh transfer starts after reset release.
- Outputs are registered (glitch-free serial_clk); no combinational path from start to any output.
- Counters are sized clog2(NPADS*CFGW+1) and clog2(DIV+1); no wrap within a transfer.

Test Plan (NPADS=2, CFGW=4, DIV=1 unless stated):
- AUTOLOAD=0, cfg_bus=8'hA5, start pulse:
  - serial_data bits on serial_clk rising edges = 1,0,1,0,0,1,0,1.
  - busy high 17 cycles.
  - serial_load high 1 cycle after the 8th rise.
  - done pulse next cycle.
  - Chain model: pad1=4'hA, pad0=4'h5.
- AUTOLOAD=1, cfg_bus=8'h3C, release nreset and never assert start:
  - Transfer begins automatically; chain model ends pad1=4'h3, pad0=4'hC.
  - No second transfer follows.
- DIV=3, cfg_bus=8'hFF:
  - serial_clk low 3 and high 3 cycles per bit.
  - busy high 2*3*8+3 = 51 cycles.
  - serial_load high 3 cycles.
- Start during transfer:
  - Pulse start at busy cycle 5 with cfg_bus changed to 8'h00.
  - The original image completes unchanged; done pulses once; no second transfer.
- Reset mid-transfer:
  - Assert nreset low after 4 serial_clk rises.
  - All outputs are 0 asynchronously and serial_load never asserted; chain active config is unchanged.
  - A new start with 8'h96 loads pad1=4'h9, pad0=4'h6.
- NPADS=1, CFGW=1:
  - cfg_bus=1 gives one serial_clk rise with data 1, busy 3 cycles, then done.

Source files
------------

// File: rtl/oh_pads_cfgload.sv
// rtl/oh_pads_cfgload.sv - serial loader for the pad-ring configuration daisy chain
module oh_pads_cfgload #(
  parameter int NPADS    = 16,
  parameter int CFGW     = 13,
  parameter int DIV      = 2,
  parameter int AUTOLOAD = 1
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   start,
  input  logic [NPADS*CFGW-1:0]  cfg_bus,
  output logic                   serial_clk,
  output logic                   serial_data,
  output logic                   serial_load,
  output logic                   busy,
  output logic                   done
);

  localparam int NBITS = NPADS * CFGW;
  localparam int BW    = $clog2(NBITS + 1);
  localparam int DW    = $clog2(DIV + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NBITS - 1);
  localparam logic [DW-1:0] LAST_TICK = DW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SLO  = 3'd1,
    SHI  = 3'd2,
    LOAD = 3'd3,
    FIN  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [DW-1:0]    tick_q, tick_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic             pend_q, pend_d;

  logic sclk_q, sclk_d;
  logic sdata_q, sdata_d;
  logic sload_q, sload_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic phase_end;
  logic trigger;

  assign phase_end = (tick_q == LAST_TICK);
  // A pending autoload counts as a start; both in the same cycle still make one transfer.
  assign trigger   = start | ((AUTOLOAD != 0) && pend_q);

  // State, counters, image and registered outputs; reset aborts without ever raising load.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      pend_q  <= 1'b1;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      sload_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      pend_q  <= pend_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      sload_q <= sload_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Sequencing: each bit is DIV cycles low then DIV cycles high, then a DIV-cycle load strobe.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          shreg_d = cfg_bus;
          pend_d  = 1'b0;
          bit_d   = '0;
          tick_d  = '0;
          state_d = SLO;
        end
      end
      SLO: begin
        if (phase_end) begin
          tick_d  = '0;
          state_d = SHI;
        end else begin
          tick_d = tick_q + DW'(1);
        end
      end
      SHI: begin
        if (phase_end) begin
          tick_d  = '0;
          shreg_d = shreg_q << 1;
          bit_d   = bit_q + BW'(1);
          state_d = (bit_q == LAST_BIT) ? LOAD : SLO;
        end else begin
          tick_d = tick_q + DW'(1);
        end
      end
      LOAD: begin
        if (phase_end) begin
          tick_d  = '0;
          state_d = FIN;
        end else begin
          tick_d = tick_q + DW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the next state so the output flops change together with the state.
  always_comb begin
    sclk_d  = (state_d == SHI);
    sdata_d = ((state_d == SLO) || (state_d == SHI)) && shreg_d[NBITS-1];
    sload_d = (state_d == LOAD);
    busy_d  = (state_d == SLO) || (state_d == SHI) || (state_d == LOAD);
    done_d  = (state_d == FIN);
  end

  assign serial_clk  = sclk_q;
  assign serial_data = sdata_q;
  assign serial_load = sload_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
